sigmon_trigger_ctrl: RTL and testbench

Sequencer for the sigmon configurable logic blocks (CLBs). Runs one capture sequence per arm request: enables the CLBs, enforces a minimum pre-trigger capture window, and evaluates a masked and polarised trigger over the four CLB outputs. After the trigger it runs a post-trigger window, then stops. Drives the CLB enable and the sample-buffer write enable. Sits between the sigmon register file and the CLB array / capture buffer.

---
 rtl/sigmon_trigger_ctrl.sv | 130 +++++++++++++
 tb/tb_sigmon_trigger_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sigmon_trigger_ctrl.sv
// sigmon_trigger_ctrl: CLB capture sequencer with pre/post windows and masked, polarised trigger.
// Define SIGMON_TRIG_OCCURRENCE_EN to fire only on the Nth trigger hit while ARMED.
module sigmon_trigger_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_arm,
  input  logic             cfg_abort,
  input  logic             cfg_force_trig,
  input  logic [3:0]       cfg_trig_mask,
  input  logic [3:0]       cfg_trig_polarity,
  input  logic             cfg_trig_mode,
  input  logic [CNT_W-1:0] cfg_pre_count,
  input  logic [CNT_W-1:0] cfg_post_count,
`ifdef SIGMON_TRIG_OCCURRENCE_EN
  input  logic [15:0]      cfg_trig_occurrence,
`endif
  input  logic [3:0]       clbs_out,
  output logic             clbs_enable,
  output logic             capture_en,
  output logic [CNT_W-1:0] trig_timestamp,
  output logic [3:0]       trig_source,
  output logic [2:0]       status_state,
  output logic             done_irq
);
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] pre_q, pre_d, post_q, post_d, ts_q, ts_d, tts_q, tts_d;
  logic [3:0] src_q, src_d, b;
  logic en_q, en_d, irq_q, irq_d, cond, hit, fire;
`ifdef SIGMON_TRIG_OCCURRENCE_EN
  logic [15:0] occ_q, occ_d, occ_inc, occ_tgt;
`endif

  always_comb begin
    b = clbs_out ^ cfg_trig_polarity;
    cond = cfg_trig_mode ? |(b & cfg_trig_mask)
                         : (cfg_trig_mask != 4'd0) && (&(b | ~cfg_trig_mask));
    hit = cond | cfg_force_trig;
  end

`ifdef SIGMON_TRIG_OCCURRENCE_EN
  always_comb begin
    occ_inc = (occ_q == 16'hFFFF) ? occ_q : occ_q + 16'd1;
    occ_tgt = (cfg_trig_occurrence == 16'd0) ? 16'd1 : cfg_trig_occurrence;
    fire = hit && (occ_inc == occ_tgt);
    occ_d = occ_q;
    if (state_d == ARMED && state_q != ARMED) occ_d = 16'd0;
    else if (state_q == ARMED && hit) occ_d = occ_inc;
  end
`else
  assign fire = hit;
`endif

  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    post_d = post_q;
    ts_d = ts_q + CNT_W'(1);
    tts_d = tts_q;
    src_d = src_q;
    case (state_q)
      IDLE, DONE: if (cfg_arm) begin
        state_d = (cfg_pre_count == '0) ? ARMED : PRE;
        pre_d = cfg_pre_count;
      end
      PRE: begin
        pre_d = pre_q - CNT_W'(1);
        if (pre_q == CNT_W'(1)) state_d = ARMED;
      end
      ARMED: if (fire) begin
        tts_d = ts_q;
        src_d = b & cfg_trig_mask;
        state_d = (cfg_post_count == '0) ? DONE : POST;
        post_d = cfg_post_count;
      end
      POST: begin
        post_d = post_q - CNT_W'(1);
        if (post_q == CNT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // abort outranks arm and trigger, and must not disturb the last trigger record
    if (cfg_abort) begin
      state_d = IDLE;
      pre_d = '0;
      post_d = '0;
      tts_d = tts_q;
      src_d = src_q;
    end
    en_d = state_d inside {PRE, ARMED, POST};
    irq_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q <= '0;
      post_q <= '0;
      ts_q <= '0;
      tts_q <= '0;
      src_q <= '0;
      en_q <= 1'b0;
      irq_q <= 1'b0;
`ifdef SIGMON_TRIG_OCCURRENCE_EN
      occ_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      post_q <= post_d;
      ts_q <= ts_d;
      tts_q <= tts_d;
      src_q <= src_d;
      en_q <= en_d;
      irq_q <= irq_d;
`ifdef SIGMON_TRIG_OCCURRENCE_EN
      occ_q <= occ_d;
`endif
    end
  end

  assign clbs_enable = en_q;
  assign capture_en = en_q;
  assign trig_timestamp = tts_q;
  assign trig_source = src_q;
  assign status_state = state_q;
  assign done_irq = irq_q;
endmodule

// File: tb/tb_sigmon_trigger_ctrl.sv
// tb_sigmon_trigger_ctrl: randomized sequences against a sequence-level model, scoreboard on done_irq.
module tb_sigmon_trigger_ctrl;
`ifdef SIGMON_TRIG_OCCURRENCE_EN
  localparam int unsigned OCC_MAX = 3;
  logic [15:0] cfg_trig_occurrence = 16'd0;
`else
  localparam int unsigned OCC_MAX = 0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic cfg_arm = 1'b0, cfg_abort = 1'b0, cfg_force_trig = 1'b0, cfg_trig_mode = 1'b0;
  logic [3:0] cfg_trig_mask = 4'd0, cfg_trig_polarity = 4'd0, clbs_out = 4'd0;
  logic [31:0] cfg_pre_count = 32'd0, cfg_post_count = 32'd0;
  logic clbs_enable, capture_en, done_irq;
  logic [31:0] trig_timestamp;
  logic [3:0] trig_source;
  logic [2:0] status_state;

  typedef struct {
    int unsigned ts;
    logic [3:0]  src;
    int unsigned d;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int tests = 0, fails = 0;
  int unsigned cyc = 0, win_lo = 1, win_hi = 0, last_tts = 0;
  logic [3:0] last_src = 4'd0;

  sigmon_trigger_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_force_trig(cfg_force_trig),
    .cfg_trig_mask(cfg_trig_mask), .cfg_trig_polarity(cfg_trig_polarity),
    .cfg_trig_mode(cfg_trig_mode), .cfg_pre_count(cfg_pre_count),
    .cfg_post_count(cfg_post_count),
`ifdef SIGMON_TRIG_OCCURRENCE_EN
    .cfg_trig_occurrence(cfg_trig_occurrence),
`endif
    .clbs_out(clbs_out), .clbs_enable(clbs_enable), .capture_en(capture_en),
    .trig_timestamp(trig_timestamp), .trig_source(trig_source),
    .status_state(status_state), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  // cycle index since reset release; equals the timestamp the DUT should show
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (!reset) begin
    chk("capture_en", 32'(capture_en), 32'(cyc >= win_lo && cyc <= win_hi));
    chk("clbs_enable", 32'(clbs_enable), 32'(cyc >= win_lo && cyc <= win_hi));
    if (done_irq) begin
      if (q.size() == 0) chk("done_irq_unexpected", 32'(done_irq), 32'd0);
      else begin
        me = q.pop_front();
        chk("done_cycle", cyc, me.d);
        chk("trig_timestamp", trig_timestamp, me.ts);
        chk("trig_source", 32'(trig_source), 32'(me.src));
        chk("done_state", 32'(status_state), 32'd4);
      end
    end
  end

  task automatic run_seq(input int unsigned pre, input int unsigned post,
                         input logic [3:0] mask, input logic [3:0] pol, input logic mode,
                         input bit rnd, input int unsigned dly, input logic [3:0] pat,
                         input int fdly, input bit ab, input bit rst_post, input int unsigned occ);
    int unsigned c, a, k, n, d, hits, tgt;
    logic [3:0] b;
    bit cond, hit;
    cfg_pre_count = pre;
    cfg_post_count = post;
    cfg_trig_mask = mask;
    cfg_trig_polarity = pol;
    cfg_trig_mode = mode;
`ifdef SIGMON_TRIG_OCCURRENCE_EN
    cfg_trig_occurrence = 16'(occ);
`endif
    tgt = (occ == 0) ? 1 : occ;
    hits = 0;
    n = 0;
    c = cyc;
    a = c + pre + 1;
    cfg_arm = 1'b1;
    win_lo = c + 1;
    win_hi = 32'hFFFF_FFFF;
    tick();
    forever begin
      k = cyc;
      clbs_out = rnd ? 4'($urandom) : ((k >= c + dly) ? pat : 4'd0);
      cfg_force_trig = rnd ? ($urandom_range(0, 7) == 0) : (fdly >= 0 && k == c + fdly);
      cfg_arm = rnd && k < a && $urandom_range(0, 3) == 0;
      if (k >= a + 60) cfg_force_trig = 1'b1;
      if (ab && k == a) begin
        cfg_abort = 1'b1;
        cfg_arm = 1'b1;
        cfg_force_trig = 1'b1;
        win_hi = k;
        tick();
        cfg_abort = 1'b0;
        cfg_arm = 1'b0;
        cfg_force_trig = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'(status_state), 32'd0);
        chk("abort_tts", trig_timestamp, last_tts);
        chk("abort_src", 32'(trig_source), 32'(last_src));
        chk("abort_irq", 32'(done_irq), 32'd0);
        tick();
        return;
      end
      if (k >= a) begin
        b = clbs_out ^ pol;
        cond = mode ? ((b & mask) != 4'd0) : (mask != 4'd0 && (b & mask) == mask);
        hit = cond || cfg_force_trig;
        if (hit) hits++;
        if (hit && hits == tgt) begin
          n = k;
          last_tts = n;
          last_src = b & mask;
          win_hi = n + post;
          q.push_back('{n, b & mask, n + 1 + post});
          break;
        end
      end
      tick();
    end
    d = n + 1 + post;
    tick();
    cfg_force_trig = 1'b0;
    cfg_arm = 1'b0;
    clbs_out = 4'($urandom);
    if (rst_post && post >= 2) begin
      #2;
      win_lo = 1;
      win_hi = 0;
      reset = 1'b1;
      #1;
      chk("rst_capture_en", 32'(capture_en), 32'd0);
      chk("rst_clbs_enable", 32'(clbs_enable), 32'd0);
      chk("rst_state", 32'(status_state), 32'd0);
      chk("rst_irq", 32'(done_irq), 32'd0);
      chk("rst_tts", trig_timestamp, 32'd0);
      chk("rst_src", 32'(trig_source), 32'd0);
      q.delete();
      last_tts = 0;
      last_src = 4'd0;
      tick();
      reset = 1'b0;
      tick();
      return;
    end
    while (cyc <= d) tick();
    chk("done_seen", q.size(), 32'd0);
    q.delete();
    @(negedge clk);
    chk("done_hold_state", 32'(status_state), 32'd4);
    chk("done_hold_irq", 32'(done_irq), 32'd0);
    tick();
  endtask

  initial begin
    clbs_out = 4'b1111;
    cfg_arm = 1'b1;
    cfg_force_trig = 1'b1;
    @(negedge clk);
    chk("reset_capture_en", 32'(capture_en), 32'd0);
    chk("reset_clbs_enable", 32'(clbs_enable), 32'd0);
    chk("reset_state", 32'(status_state), 32'd0);
    chk("reset_irq", 32'(done_irq), 32'd0);
    chk("reset_tts", trig_timestamp, 32'd0);
    chk("reset_src", 32'(trig_source), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cfg_arm = 1'b0;
    cfg_force_trig = 1'b0;
    clbs_out = 4'd0;
    tick();
    tick();
    run_seq(4, 3, 4'b0001, 4'b0000, 1'b0, 0, 10, 4'b0001, -1, 0, 0, 0);
    run_seq(2, 2, 4'b0110, 4'b0100, 1'b1, 0, 0, 4'b0000, -1, 0, 0, 0);
    run_seq(0, 0, 4'b0000, 4'b0000, 1'b0, 0, 0, 4'b1111, 7, 0, 0, 0);
    run_seq(1, 2, 4'b0001, 4'b0000, 1'b0, 0, 0, 4'b0001, -1, 1, 0, 0);
    run_seq(1, 5, 4'b0001, 4'b0000, 1'b0, 0, 0, 4'b0001, -1, 0, 1, 0);
    repeat (40)
      run_seq($urandom_range(0, 5), $urandom_range(0, 5), 4'($urandom), 4'($urandom),
              1'($urandom), 1, 0, 4'd0, -1, $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, OCC_MAX));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
